// File: rtl/data_mem_pkg.sv
// data_mem_pkg: size and state encodings shared by the load/store controller
package data_mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load extract/extend (rdata,lane,size,uns -> ld_data) and store merge (rdata,wdata,lane,size -> st_data)
module dmem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{lane, 3'b000} +: 8];
  assign h = rdata[{lane[1], 4'b0000} +: 16];
  assign ld_data = size == SIZE_BYTE ? {{24{b[7] & ~uns}}, b} :
                   size == SIZE_HALF ? {{16{h[15] & ~uns}}, h} : rdata;
  always_comb begin
    st_data = rdata;
    if (size == SIZE_BYTE) st_data[{lane, 3'b000} +: 8] = wdata[7:0];
    else st_data[{lane[1], 4'b0000} +: 16] = wdata;
  end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte/half/word load-store controller onto a word-addressed registered-read memory (req_* in, rsp_* out, mem_* to memory)
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q, size_q;
  logic                  uns_q;
  logic [15:0]           wdata_q;
  logic                  accept, mis, go, word_st;
  logic [DATA_WIDTH-1:0] ld_data, st_data;
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign mis = req_size == 2'b11 || (req_size == SIZE_HALF && req_addr[0]) ||
               (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
  assign go = accept && !mis;
  assign word_st = req_we && req_size == SIZE_WORD;
  dmem_lane_align u_align (
    .rdata(mem_rdata),
    .wdata(wdata_q),
    .lane(lane_q),
    .size(size_q),
    .uns(uns_q),
    .ld_data(ld_data),
    .st_data(st_data)
  );
  always_comb begin
    mem_addr = state == RMW ? addr_q : req_addr[ADDR_WIDTH+1:2];
    mem_we = !rst && (state == RMW || (go && word_st));
    mem_wdata = state == RMW ? st_data : req_wdata;
    state_d = state == IDLE && go && !req_we ? LOAD :
              state == IDLE && go && !word_st ? RMW : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      state <= state_d;
      rsp_valid <= state != IDLE || (accept && (mis || word_st));
      rsp_rdata <= state == LOAD ? ld_data : '0;
      rsp_misaligned <= accept && mis;
    end
  end
  always_ff @(posedge clk) begin
    if (go) begin
      addr_q <= req_addr[ADDR_WIDTH+1:2];
      lane_q <= req_addr[1:0];
      size_q <= req_size;
      uns_q <= req_unsigned;
      wdata_q <= req_wdata[15:0];
    end
  end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed self-checking bench for data_mem_lsu with a registered-read memory model
module tb_data_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:255];
  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;
  int          we_base;
  always #5 clk = ~clk;
  data_mem_lsu dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata);
    drive(we, size, uns, addr, wdata);
    tick();
    req_valid = 1'b0;
  endtask
  task automatic word_store(input logic [9:0] addr, input logic [31:0] wdata);
    issue(1'b1, 2'b10, 1'b0, addr, wdata);
    chk("wst_rsp", {31'b0, rsp_valid}, 32'd1);
  endtask
  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [9:0] addr, input logic [31:0] exp);
    issue(1'b0, size, uns, addr, 32'h0);
    chk({tag, "_t1_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_t1_ready"}, {31'b0, req_ready}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_mis"}, {31'b0, rsp_misaligned}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
  endtask
  task automatic sub_store(input string tag, input logic [1:0] size, input logic [9:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp);
    issue(1'b1, size, 1'b0, addr, wdata);
    chk({tag, "_rmw_we"}, {31'b0, mem_we}, 32'd1);
    chk({tag, "_rmw_addr"}, {24'b0, mem_addr}, {24'b0, addr[9:2]});
    chk({tag, "_rmw_wdata"}, mem_wdata, exp);
    chk({tag, "_t1_valid"}, {31'b0, rsp_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_mem"}, mem[addr[9:2]], exp);
  endtask
  task automatic misaligned(input string tag, input logic we, input logic [1:0] size, input logic [9:0] addr);
    we_base = we_cnt;
    drive(we, size, 1'b0, addr, 32'hFFFF_FFFF);
    #1;
    chk({tag, "_we_comb"}, {31'b0, mem_we}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_mis"}, {31'b0, rsp_misaligned}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    tick();
    chk({tag, "_once"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_no_we"}, we_cnt - we_base, 32'd0);
    chk({tag, "_mem"}, mem[4], 32'h8001_0000);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mis", {31'b0, rsp_misaligned}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    req_addr = 10'h2C;
    #1;
    chk("idle_addr", {24'b0, mem_addr}, 32'h0B);
    chk("idle_we", {31'b0, mem_we}, 32'd0);
    tick();
    drive(1'b1, 2'b10, 1'b0, 10'h10, 32'hDEAD_BEEF);
    #1;
    chk("wst_we", {31'b0, mem_we}, 32'd1);
    chk("wst_addr", {24'b0, mem_addr}, 32'h04);
    chk("wst_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    req_valid = 1'b0;
    chk("wst_valid", {31'b0, rsp_valid}, 32'd1);
    chk("wst_mis", {31'b0, rsp_misaligned}, 32'd0);
    chk("wst_rdata", rsp_rdata, 32'h0);
    chk("wst_ready", {31'b0, req_ready}, 32'd1);
    chk("wst_mem", mem[4], 32'hDEAD_BEEF);
    load("lw", 2'b10, 1'b0, 10'h10, 32'hDEAD_BEEF);
    word_store(10'h10, 32'h1122_3344);
    sub_store("sb", 2'b00, 10'h11, 32'h0000_00A5, 32'h1122_A544);
    load("lb", 2'b00, 1'b0, 10'h11, 32'hFFFF_FFA5);
    load("lbu", 2'b00, 1'b1, 10'h11, 32'h0000_00A5);
    load("lb0", 2'b00, 1'b0, 10'h10, 32'h0000_0044);
    word_store(10'h10, 32'h0000_0000);
    sub_store("sh", 2'b01, 10'h12, 32'h0000_8001, 32'h8001_0000);
    load("lh", 2'b01, 1'b0, 10'h12, 32'hFFFF_8001);
    load("lhu", 2'b01, 1'b1, 10'h12, 32'h0000_8001);
    load("lb3", 2'b00, 1'b0, 10'h13, 32'hFFFF_FF80);
    misaligned("mis_lw", 1'b0, 2'b10, 10'h13);
    misaligned("mis_sh", 1'b1, 2'b01, 10'h11);
    misaligned("mis_sz", 1'b0, 2'b11, 10'h10);
    drive(1'b1, 2'b10, 1'b0, 10'h00, 32'hA0A0_0000);
    tick();
    chk("b2b_v0", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_r0", {31'b0, req_ready}, 32'd1);
    drive(1'b1, 2'b10, 1'b0, 10'h04, 32'hA0A0_0004);
    tick();
    chk("b2b_v1", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_r1", {31'b0, req_ready}, 32'd1);
    drive(1'b1, 2'b10, 1'b0, 10'h08, 32'hA0A0_0008);
    tick();
    req_valid = 1'b0;
    chk("b2b_v2", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_r2", {31'b0, req_ready}, 32'd1);
    tick();
    chk("b2b_end", {31'b0, rsp_valid}, 32'd0);
    chk("b2b_m0", mem[0], 32'hA0A0_0000);
    chk("b2b_m1", mem[1], 32'hA0A0_0004);
    chk("b2b_m2", mem[2], 32'hA0A0_0008);
    word_store(10'h20, 32'hCAFE_F00D);
    issue(1'b1, 2'b00, 1'b0, 10'h20, 32'h0000_0055);
    chk("rrst_rmw", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rrst_we", {31'b0, mem_we}, 32'd0);
    chk("rrst_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("rrst_valid", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rrst_ready_after", {31'b0, req_ready}, 32'd1);
    tick();
    chk("rrst_valid2", {31'b0, rsp_valid}, 32'd0);
    chk("rrst_mem", mem[8], 32'hCAFE_F00D);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store controller between the core's memory stage and the word-addressed, single-port, registered-read data memory. Accepts byte-addressed requests of byte/half/word size and maps them onto whole-word memory accesses. Sub-word stores are done as read-modify-write. Load data is extracted and sign/zero-extended, and misaligned accesses are flagged without touching memory.

## Interface
- ADDR_WIDTH, 8, word-address width of the data memory; byte address is ADDR_WIDTH+2 bits
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes)

Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; transfer when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte)
- rsp_valid  out  1  one-cycle completion pulse, registered
- rsp_rdata  out  32  formatted load data; 0 for stores/errors
- rsp_misaligned  out  1  valid with rsp_valid; access rejected
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after the address edge

## Operation
- States: IDLE, LOAD, RMW. req_ready = (state==IDLE) && !rst.
- Misaligned when: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- Misaligned requests get rsp_valid with rsp_misaligned=1 and rsp_rdata=0. There is no memory write, and the state stays IDLE.
- IDLE, no request: mem_addr = req_addr[ADDR_WIDTH+1:2] combinationally, and mem_we = 0.
- Accepted aligned load: the address is issued in the same cycle. Latch lane = addr[1:0], size and unsigned. Go to LOAD.
- LOAD: format mem_rdata into rsp_rdata and register it; pulse rsp_valid; go to IDLE.
  - Byte: rdata[8*lane +: 8].
  - Half: rdata[16*lane[1] +: 16].
  - Word: the full word.
  - Sign-extend from the top bit unless unsigned.
- Accepted aligned word store: mem_we=1 and mem_wdata=req_wdata in the accept cycle. rsp_valid is pulsed next cycle. Stay IDLE, so back-to-back word stores are allowed.
- Accepted aligned byte/half store: issue a read of the word and latch the word address, lane, size and wdata. Go to RMW.
- RMW: mem_addr = the latched address and mem_we=1. mem_wdata = mem_rdata with the selected lane(s) replaced by latched wdata[7:0] or [15:0]. Pulse rsp_valid next cycle; go to IDLE.
- Little-endian lane order: lane 0 = bits [7:0].
- Reset (at any cycle, including mid-LOAD or mid-RMW):
  - Next state is IDLE, with rsp_valid=0, rsp_rdata=0 and rsp_misaligned=0.
  - mem_we is gated by !rst, so a pending RMW write is dropped.
  - req_ready=0 while rst is high.

## Timing
- Request accepted in cycle T.
- Aligned load: rsp_valid in T+2; next accept possible in T+2.
- Word store: memory written at the end of T; rsp_valid in T+1; next accept in T+1.
- Sub-word store: read at the end of T; write at the end of T+1; rsp_valid in T+2; next accept in T+2.
- Misaligned or illegal request: rsp_valid in T+1; no mem_we in any cycle.
- rsp_valid is high for exactly one cycle per accepted request. There is no backpressure on the response.
- mem_we and mem_addr are combinational from state, latched values and the request. All rsp_* outputs are registers.

## Structure
- Package data_mem_pkg:
  - Size encodings: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - State encoding: IDLE, LOAD, RMW.
- Sub-module dmem_lane_align (purely combinational) provides:
  - Load extract/extend: rdata, lane, size, unsigned → formatted data.
  - Store merge: old word, wdata, lane, size → merged word.
- Top level holds the FSM, the request latches and the response registers.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 → store rsp at T+1; load rsp at T+2 with rdata 0xDEADBEEF and misaligned=0.
- Byte store 0xA5 to addr 0x11 over word 0x11223344 → memory word becomes 0x1122A544. Signed byte load from 0x11 returns 0xFFFFFFA5; unsigned returns 0x000000A5.
- Half store 0x8001 to addr 0x12 over word 0x00000000 → word 0x80010000. Signed half load from 0x12 returns 0xFFFF8001.
- Misaligned requests each give rsp_misaligned=1, rdata 0 at T+1, with mem_we never asserted and memory unchanged:
  - Word load at 0x13.
  - Half store at 0x11.
  - size=11 at 0x10.
- Back-to-back word stores to 0x0, 0x4, 0x8 on consecutive cycles → req_ready stays high, three rsp pulses, all three words written.
- Assert rst in the RMW cycle of a byte store to 0x20 → no mem_we in that cycle, original word intact, no rsp_valid, req_ready=1 the cycle after rst drops.
